// File: rtl/alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_loader
// Brief    : Stages NUM_OPERANDS operands plus a mode word, then publishes the
//            whole bundle to the ALU atomically under a valid/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_loader #(
    parameter  int DATA_WIDTH   = 8,
    parameter  int MODE_WIDTH   = 6,
    parameter  int NUM_OPERANDS = 2,
    localparam int BUS_WIDTH    = (DATA_WIDTH > MODE_WIDTH) ? DATA_WIDTH : MODE_WIDTH,
    localparam int IDX_WIDTH    = $clog2(NUM_OPERANDS + 1)
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic [BUS_WIDTH-1:0]               i_data_bus,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic                               i_clear,
    input  logic                               i_ack,
    output logic [NUM_OPERANDS*DATA_WIDTH-1:0] o_operands,
    output logic [MODE_WIDTH-1:0]              o_mode,
    output logic                               o_valid,
    output logic [IDX_WIDTH-1:0]               o_index
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [IDX_WIDTH-1:0] C_MODE_IDX = IDX_WIDTH'(NUM_OPERANDS);

    state_t                             r_state;
    state_t                             w_state_nxt;
    logic [IDX_WIDTH-1:0]               r_index;
    logic [IDX_WIDTH-1:0]               w_index_nxt;
    logic                               r_valid;
    logic                               w_valid_nxt;
    logic [DATA_WIDTH-1:0]              r_stage [NUM_OPERANDS];
    logic [MODE_WIDTH-1:0]              r_stage_mode;
    logic [NUM_OPERANDS*DATA_WIDTH-1:0] w_stage_flat;
    logic [NUM_OPERANDS*DATA_WIDTH-1:0] r_operands;
    logic [MODE_WIDTH-1:0]              r_mode;
    logic [MODE_WIDTH-1:0]              w_pub_mode;
    logic                               w_publish;
    logic                               w_accept;
    logic                               w_mode_slot;

    assign o_ready     = (r_state == FILL) && !i_reset;
    assign w_accept    = i_valid && o_ready && !i_clear;
    assign w_mode_slot = (r_index == C_MODE_IDX);

    for (genvar k = 0; k < NUM_OPERANDS; k++) begin : g_flat
        assign w_stage_flat[k*DATA_WIDTH +: DATA_WIDTH] = r_stage[k];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_valid_nxt = r_valid;
        w_publish   = 1'b0;
        w_pub_mode  = r_stage_mode;
        if (i_clear) begin
            w_state_nxt = FILL;
            w_index_nxt = '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (w_mode_slot) begin
                            // Mode word bypasses staging when the output slot is free
                            if (!r_valid || i_ack) begin
                                w_publish   = 1'b1;
                                w_pub_mode  = i_data_bus[MODE_WIDTH-1:0];
                                w_index_nxt = '0;
                            end else begin
                                w_state_nxt = WAIT;
                            end
                        end else begin
                            w_index_nxt = r_index + IDX_WIDTH'(1);
                        end
                    end
                end
                WAIT: begin
                    if (i_ack) begin
                        w_publish   = 1'b1;
                        w_index_nxt = '0;
                        w_state_nxt = FILL;
                    end
                end
                default: w_state_nxt = FILL;
            endcase
        end
        if (w_publish) begin
            w_valid_nxt = 1'b1;
        end else if (i_ack) begin
            w_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= FILL;
            r_index <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_OPERANDS; k++) begin
                r_stage[k] <= '0;
            end
            r_stage_mode <= '0;
            r_operands   <= '0;
            r_mode       <= '0;
        end else begin
            for (int k = 0; k < NUM_OPERANDS; k++) begin
                if (w_accept && (r_index == IDX_WIDTH'(k))) begin
                    r_stage[k] <= i_data_bus[DATA_WIDTH-1:0];
                end
            end
            if (w_accept && w_mode_slot) begin
                r_stage_mode <= i_data_bus[MODE_WIDTH-1:0];
            end
            if (w_publish) begin
                r_operands <= w_stage_flat;
                r_mode     <= w_pub_mode;
            end
        end
    end

    assign o_operands = r_operands;
    assign o_mode     = r_mode;
    assign o_valid    = r_valid;
    assign o_index    = r_index;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_loader
// Brief    : Directed stimulus for alu_operand_loader, checked every cycle
//            against a queue-based bundle model plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_loader;

    localparam int DW = 8;
    localparam int MW = 6;
    localparam int N  = 2;
    localparam int BW = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [BW-1:0]   bus = '0;
    logic            vld = 1'b0;
    logic            clr = 1'b0;
    logic            ack = 1'b0;
    logic            rdy;
    logic [N*DW-1:0] ops;
    logic [MW-1:0]   mode;
    logic            ovld;
    logic [IW-1:0]   idx;

    int n_cmp = 0;
    int n_err = 0;

    alu_operand_loader #(.DATA_WIDTH(DW), .MODE_WIDTH(MW), .NUM_OPERANDS(N)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_data_bus (bus),
        .i_valid    (vld),
        .o_ready    (rdy),
        .i_clear    (clr),
        .i_ack      (ack),
        .o_operands (ops),
        .o_mode     (mode),
        .o_valid    (ovld),
        .o_index    (idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: words accepted since the bundle started, a held full bundle, and
    // the last published bundle.
    logic [BW-1:0]   words[$];
    bit              pending = 0;
    bit              started = 0;
    logic [N*DW-1:0] m_ops   = '0;
    logic [MW-1:0]   m_mode  = '0;
    bit              m_valid = 0;

    task automatic model_publish();
        logic [BW-1:0] w;
        for (int k = 0; k < N; k++) begin
            w = words[k];
            m_ops[k*DW +: DW] = w[DW-1:0];
        end
        w       = words[N];
        m_mode  = w[MW-1:0];
        m_valid = 1;
        words.delete();
    endtask

    always @(posedge clk) begin
        bit ack_eff;
        bit pub;
        started = 1;
        if (rst) begin
            words.delete();
            pending = 0;
            m_valid = 0;
            m_ops   = '0;
            m_mode  = '0;
        end else begin
            ack_eff = ack && m_valid;
            pub     = 0;
            if (clr) begin
                words.delete();
                pending = 0;
            end else if (pending) begin
                if (ack_eff) begin
                    model_publish();
                    pending = 0;
                    pub     = 1;
                end
            end else if (vld) begin
                words.push_back(bus);
                if (words.size() == N + 1) begin
                    if (!m_valid || ack_eff) begin
                        model_publish();
                        pub = 1;
                    end else begin
                        pending = 1;
                    end
                end
            end
            if (ack_eff && !pub) m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("ready", 32'(rdy), 32'(!pending && !rst));
            check("index", 32'(idx), pending ? N : words.size());
            check("valid", 32'(ovld), 32'(m_valid));
            check("operands", 32'(ops), 32'(m_ops));
            check("mode", 32'(mode), 32'(m_mode));
        end
    end

    task automatic step(input logic v, input logic [BW-1:0] d, input logic c,
                        input logic a, input logic r);
        vld = v; bus = d; clr = c; ack = a; rst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with a word offered
        step(1, 8'h55, 0, 0, 1);
        step(1, 8'h55, 0, 0, 1);
        check("rst_ops", 32'(ops), 32'h0);
        check("rst_mode", 32'(mode), 32'h0);
        check("rst_valid", 32'(ovld), 32'h0);
        check("rst_index", 32'(idx), 32'h0);
        check("rst_ready", 32'(rdy), 32'h0);
        step(0, 8'h00, 0, 0, 0);
        check("post_rst_ready", 32'(rdy), 32'h1);

        // Basic load
        step(1, 8'h05, 0, 0, 0);
        check("basic_idx1", 32'(idx), 32'h1);
        step(1, 8'hFD, 0, 0, 0);
        check("basic_idx2", 32'(idx), 32'h2);
        check("basic_early_valid", 32'(ovld), 32'h0);
        step(1, 8'hA0, 0, 0, 0);
        check("basic_ops", 32'(ops), 32'hFD05);
        check("basic_mode", 32'(mode), 32'h20);
        check("basic_valid", 32'(ovld), 32'h1);
        check("basic_idx0", 32'(idx), 32'h0);

        // Backpressure
        step(1, 8'h11, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0);
        step(1, 8'h03, 0, 0, 0);
        check("bp_ready", 32'(rdy), 32'h0);
        check("bp_idx", 32'(idx), 32'h2);
        check("bp_ops_held", 32'(ops), 32'hFD05);
        check("bp_mode_held", 32'(mode), 32'h20);
        step(0, 8'h00, 0, 1, 0);
        check("bp_ops", 32'(ops), 32'h2211);
        check("bp_mode", 32'(mode), 32'h03);
        check("bp_valid", 32'(ovld), 32'h1);
        check("bp_ready_after", 32'(rdy), 32'h1);

        // Clear mid-load drops the concurrent word
        step(1, 8'h01, 0, 0, 0);
        step(1, 8'h99, 1, 0, 0);
        check("clr_idx", 32'(idx), 32'h0);
        step(1, 8'h07, 0, 0, 0);
        step(1, 8'h08, 0, 0, 0);
        step(1, 8'h02, 0, 1, 0);
        check("clr_ops", 32'(ops), 32'h0807);
        check("clr_mode", 32'(mode), 32'h02);

        // Ack without new data, then a redundant ack
        step(0, 8'h00, 0, 1, 0);
        check("ack_valid", 32'(ovld), 32'h0);
        check("ack_ops_held", 32'(ops), 32'h0807);
        step(0, 8'h00, 0, 1, 0);
        check("ack2_valid", 32'(ovld), 32'h0);
        check("ack2_mode_held", 32'(mode), 32'h02);

        // Reach WAIT, then reset
        step(1, 8'h10, 0, 0, 0);
        step(1, 8'h20, 0, 0, 0);
        step(1, 8'hFF, 0, 0, 0);
        check("trunc_mode", 32'(mode), 32'h3F);
        step(1, 8'h11, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0);
        step(1, 8'h03, 0, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        check("wrst_ops", 32'(ops), 32'h0);
        check("wrst_valid", 32'(ovld), 32'h0);
        step(0, 8'h00, 0, 0, 0);
        check("wrst_ready", 32'(rdy), 32'h1);
        step(1, 8'h7F, 0, 0, 0);
        step(1, 8'h80, 0, 0, 0);
        step(1, 8'h3F, 0, 0, 0);
        check("wrst_next_ops", 32'(ops), 32'h807F);
        check("wrst_next_mode", 32'(mode), 32'h3F);

        // Clear and ack together in WAIT
        step(1, 8'h01, 0, 0, 0);
        step(1, 8'h02, 0, 0, 0);
        step(1, 8'h03, 0, 0, 0);
        step(0, 8'h00, 1, 1, 0);
        check("clrack_valid", 32'(ovld), 32'h0);
        check("clrack_ops", 32'(ops), 32'h807F);
        check("clrack_ready", 32'(rdy), 32'h1);

        // Streaming with ack on each mode word: no bubble
        for (int b = 0; b < 3; b++) begin
            step(1, 8'(8'h30 + b), 0, 0, 0);
            step(1, 8'(8'hC0 + b), 0, 0, 0);
            step(1, 8'(b + 1), 0, 1, 0);
        end
        check("stream_ops", 32'(ops), 32'hC232);
        check("stream_mode", 32'(mode), 32'h03);

        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
